enc_seq_ctrl: RTL and testbench
===============================

Name: enc_seq_ctrl

Overview:
- Sequencing controller for the LFSR byte-encryption datapath.
- On an encryption request it:
  - reads the parameter ROM (preamble length, taps, seed);
  - loads the datapath's tap and LFSR registers;
  - runs the preamble phase, then the payload phase, with a valid/ready handshake.
- Sits between the top-level encryption wrapper and the datapath. It drives every datapath enable and select, and generates validOut/done.

Parameters:
- AW, 8, ROM address width.
- DW, 8, ROM data width.
- MAX_PAY, 64, maximum payload bytes per request before forced termination.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- encRqst  input  1  level request to start encryption.
- validIn  input  1  payload byte present on the datapath plainByte input.
- lastIn  input  1  qualifies validIn: this is the final payload byte.
- rom_q  input  DW  synchronous ROM read data (1-cycle latency from raddr).
- raddr  output  AW  ROM read address.
- taps_en  output  1  datapath captures rom_q into the taps register.
- lfsr_ld  output  1  datapath loads rom_q into the LFSR state.
- lfsr_en  output  1  datapath advances the LFSR one step.
- sel_pre  output  1  1 selects the preamble char 0x7E; 0 selects plainByte (bit 7 forced to 1 in datapath).
- byte_en  output  1  datapath output register captures the encrypted byte this cycle.
- inReady  output  1  controller accepts a payload byte this cycle.
- validOut  output  1  encryptByte valid (registered byte_en).
- done  output  1  encryption complete.
- trunc  output  1  request ended by MAX_PAY, not by lastIn.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; raddr=0; validOut=0, done=0, trunc=0.
  - pre_cnt=0, pay_cnt=0.
  - All enables and selects are 0.
- States: IDLE, RD_LEN, RD_TAPS, RD_SEED, INIT, PRE, PAY, FIN.
- IDLE:
  - raddr=0.
  - encRqst=1 -> RD_LEN; trunc cleared.
- RD_LEN: raddr=0 -> RD_TAPS.
- RD_TAPS:
  - raddr=1.
  - rom_q (address 0) is captured into internal pre_cnt.
  - -> RD_SEED.
- RD_SEED:
  - raddr=2; taps_en=1 (rom_q = taps).
  - -> INIT.
- INIT:
  - lfsr_ld=1 (rom_q = seed).
  - -> PRE if pre_cnt!=0, else PAY.
- PRE, per cycle:
  - sel_pre=1, byte_en=1, lfsr_en=1; pre_cnt decrements.
  - At pre_cnt==1 -> PAY.
  - Exactly pre_len preamble bytes are produced, back-to-back.
  - inReady=0 and validIn is ignored.
- PAY:
  - inReady=1.
  - On validIn=1: sel_pre=0, byte_en=1, lfsr_en=1, pay_cnt++.
  - validIn=0 stalls; the LFSR does not advance.
  - -> FIN when the accepted byte has lastIn=1, or when pay_cnt reaches MAX_PAY (then trunc=1).
  - lastIn without validIn is ignored.
- FIN:
  - done=1, held while encRqst=1.
  - encRqst=0 -> IDLE (done deasserts next cycle); trunc holds until the next request starts.
- validOut = byte_en delayed exactly 1 cycle, so it aligns with the datapath output register.
- Latency: the first validOut is cycle 6 after encRqst is sampled, when pre_len>0.
- Mid-operation events:
  - encRqst deassert mid-operation is ignored; the sequence completes to FIN.
  - Async reset mid-operation aborts immediately to IDLE; no validOut follows reset.
- pre_len is an 8-bit unsigned value; 0 skips PRE; 255 is legal.
- pay_cnt is ceil(log2(MAX_PAY+1)) bits and cleared on entry to RD_LEN.
- lfsr_en and lfsr_ld are never high in the same cycle. taps_en precedes lfsr_ld by exactly 1 cycle.

Test Plan:
- ROM={0:4, 1:0x12, 2:0x05}, encRqst pulse, 3 payload bytes with validIn contiguous (last with lastIn) -> raddr sequence 0,0,1,2; taps_en at cycle 3, lfsr_ld at cycle 4; 4 sel_pre=1 strobes; 3 payload strobes; 7 validOut pulses; done=1; trunc=0.
- ROM len=0 -> no sel_pre cycles; the first inReady occurs the cycle after INIT.
- PAY with validIn gapped (1,0,0,1,1+lastIn) -> lfsr_en pulses only on the 3 accepted cycles; validOut count=pre_len+3.
- MAX_PAY=4, 10 bytes offered with no lastIn -> exactly 4 accepted; FIN; trunc=1; inReady=0 afterwards.
- rst=0 asserted during PRE (2 of 4 bytes sent) -> outputs are 0 immediately. A subsequent encRqst restarts from raddr=0 with a full preamble of 4.
- encRqst held high through FIN -> done stays 1 with no new read; drop encRqst -> done=0 next cycle; a re-request repeats the sequence identically.

Source files
------------

// File: rtl/enc_seq_ctrl.sv
// Sequencing controller for the LFSR byte-encryption datapath: reads the parameter ROM,
// loads taps/seed, then runs the preamble and the handshaked payload phases.
module enc_seq_ctrl #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned MAX_PAY = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          encRqst,
    input  logic          validIn,
    input  logic          lastIn,
    input  logic [DW-1:0] rom_q,
    output logic [AW-1:0] raddr,
    output logic          taps_en,
    output logic          lfsr_ld,
    output logic          lfsr_en,
    output logic          sel_pre,
    output logic          byte_en,
    output logic          inReady,
    output logic          validOut,
    output logic          done,
    output logic          trunc
);

    localparam int unsigned LW  = 8;
    localparam int unsigned PCW = $clog2(MAX_PAY + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LEN,
        RD_TAPS,
        RD_SEED,
        INIT,
        PRE,
        PAY,
        FIN
    } state_t;

    state_t         state;
    logic [LW-1:0]  pre_cnt;
    logic [PCW-1:0] pay_cnt;

    // Datapath strobes decode the current state; payload strobes follow the same-cycle handshake.
    always_comb begin
        taps_en = 1'b0;
        lfsr_ld = 1'b0;
        lfsr_en = 1'b0;
        sel_pre = 1'b0;
        byte_en = 1'b0;
        inReady = 1'b0;
        case (state)
            RD_SEED: taps_en = 1'b1;
            INIT:    lfsr_ld = 1'b1;
            PRE: begin
                sel_pre = 1'b1;
                byte_en = 1'b1;
                lfsr_en = 1'b1;
            end
            PAY: begin
                inReady = 1'b1;
                byte_en = validIn;
                lfsr_en = validIn;
            end
            default: ;
        endcase
    end

    // Sequencer: state, ROM address (set one cycle ahead to cover the ROM latency), counters, status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            raddr    <= '0;
            pre_cnt  <= '0;
            pay_cnt  <= '0;
            validOut <= 1'b0;
            done     <= 1'b0;
            trunc    <= 1'b0;
        end else begin
            validOut <= byte_en;
            case (state)
                IDLE: begin
                    raddr <= '0;
                    if (encRqst) begin
                        state   <= RD_LEN;
                        trunc   <= 1'b0;
                        pay_cnt <= '0;
                    end
                end
                RD_LEN: begin
                    raddr <= AW'(1);
                    state <= RD_TAPS;
                end
                RD_TAPS: begin
                    pre_cnt <= LW'(rom_q);
                    raddr   <= AW'(2);
                    state   <= RD_SEED;
                end
                RD_SEED: begin
                    raddr <= '0;
                    state <= INIT;
                end
                INIT: begin
                    state <= (pre_cnt != '0) ? PRE : PAY;
                end
                PRE: begin
                    pre_cnt <= pre_cnt - LW'(1);
                    if (pre_cnt == LW'(1)) begin
                        state <= PAY;
                    end
                end
                PAY: begin
                    if (validIn) begin
                        pay_cnt <= pay_cnt + PCW'(1);
                        if (lastIn) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (pay_cnt == PCW'(MAX_PAY - 1)) begin
                            // Forced termination: the byte limit ended the request, not lastIn.
                            state <= FIN;
                            done  <= 1'b1;
                            trunc <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    if (!encRqst) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enc_seq_ctrl.sv
// Randomized bench for enc_seq_ctrl: each request is checked cycle by cycle against an
// expected timeline derived from the preamble length and the offered payload pattern.
module tb_enc_seq_ctrl;

    localparam int unsigned MAX_PAY = 4;
    localparam int unsigned NP      = 48;

    logic       clk;
    logic       rst;
    logic       encRqst;
    logic       validIn;
    logic       lastIn;
    logic [7:0] rom_q;
    logic [7:0] raddr;
    logic       taps_en, lfsr_ld, lfsr_en, sel_pre, byte_en, inReady, validOut, done, trunc;

    logic [7:0] rom [0:255];
    bit         vin_a [0:NP-1];
    bit         lin_a [0:NP-1];

    int n_tests = 0;
    int n_fail  = 0;
    bit prev_tr = 1'b0;
    bit be_prev = 1'b0;

    enc_seq_ctrl #(.AW(8), .DW(8), .MAX_PAY(MAX_PAY)) dut (
        .clk      (clk),
        .rst      (rst),
        .encRqst  (encRqst),
        .validIn  (validIn),
        .lastIn   (lastIn),
        .rom_q    (rom_q),
        .raddr    (raddr),
        .taps_en  (taps_en),
        .lfsr_ld  (lfsr_ld),
        .lfsr_en  (lfsr_en),
        .sel_pre  (sel_pre),
        .byte_en  (byte_en),
        .inReady  (inReady),
        .validOut (validOut),
        .done     (done),
        .trunc    (trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) rom_q <= rom[raddr];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [16:0] obs();
        return {raddr, taps_en, lfsr_ld, lfsr_en, sel_pre, byte_en, inReady, validOut, done, trunc};
    endfunction

    // Payload pattern from bit masks (index 0 = first PAY cycle).
    task automatic set_pat(input logic [15:0] v, input logic [15:0] l);
        for (int p = 0; p < int'(NP); p++) begin
            vin_a[p] = (p < 16) ? v[p] : 1'b0;
            lin_a[p] = (p < 16) ? l[p] : 1'b0;
        end
    endtask

    task automatic rand_pat();
        bit with_last = 1'($urandom_range(0, 1));
        int nbytes    = $urandom_range(1, MAX_PAY);
        int cnt       = 0;
        for (int p = 0; p < int'(NP); p++) begin
            vin_a[p] = (p >= 40) || ($urandom_range(0, 2) != 0);
            if (vin_a[p]) begin
                cnt++;
                lin_a[p] = (cnt > nbytes) ? 1'($urandom) : (with_last && cnt == nbytes);
            end else begin
                lin_a[p] = 1'($urandom);
            end
        end
    endtask

    // One request: model the expected end from the pattern, then drive and check each cycle.
    task automatic run_txn(input int len, input int hold, input bit drop_rq, input int abort_at);
        int acc  = 0;
        int endp = -1;
        bit tr   = 1'b0;
        int ps   = 5 + len;
        int endc, total, vo_cnt;
        logic [16:0] exp_v;
        bit pre, pay, e_v, e_be, e_done, e_tr;
        logic [7:0] e_ra;

        rom[0] = 8'(len);
        for (int p = 0; p < int'(NP); p++) begin
            if (vin_a[p]) begin
                acc++;
                if (lin_a[p]) begin
                    endp = p; tr = 1'b0; break;
                end
                if (acc == int'(MAX_PAY)) begin
                    endp = p; tr = 1'b1; break;
                end
            end
        end
        if (endp < 0) begin
            $display("FAIL pattern: no terminating byte");
            $fatal(1);
        end
        endc   = ps + endp;
        total  = endc + hold + 3;
        vo_cnt = 0;

        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == 0)               encRqst = 1'b1;
            else if (c <= endc)       encRqst = drop_rq ? 1'($urandom) : 1'b1;
            else                      encRqst = (c <= endc + hold);
            if (c >= ps && c <= endc) begin
                validIn = vin_a[c - ps];
                lastIn  = lin_a[c - ps];
            end else begin
                validIn = 1'($urandom);
                lastIn  = 1'($urandom);
            end
            #1;
            e_ra   = (c == 2) ? 8'd1 : (c == 3) ? 8'd2 : 8'd0;
            pre    = (c >= 5) && (c < ps);
            pay    = (c >= ps) && (c <= endc);
            e_v    = pay ? vin_a[c - ps] : 1'b0;
            e_be   = pre | e_v;
            e_done = (c > endc) && (c <= endc + hold + 1);
            e_tr   = (c == 0) ? prev_tr : ((c > endc) ? tr : 1'b0);
            exp_v  = {e_ra, 1'(c == 3), 1'(c == 4), e_be, pre, e_be, pay, be_prev, e_done, e_tr};
            check_eq($sformatf("cyc%0d len%0d", c, len), 32'(obs()), 32'(exp_v));
            vo_cnt += int'(validOut);
            be_prev = e_be;
            if (c == abort_at) begin
                #2 rst = 1'b0;
                encRqst = 1'b0;
                validIn = 1'b0;
                #1 check_eq("rst_async", 32'(obs()), 32'd0);
                @(negedge clk);
                #1 check_eq("rst_hold", 32'(obs()), 32'd0);
                rst     = 1'b1;
                prev_tr = 1'b0;
                be_prev = 1'b0;
                return;
            end
        end
        check_eq($sformatf("vo_count len%0d", len), 32'(vo_cnt), 32'(len + acc));
        prev_tr = tr;
    endtask

    initial begin
        rst     = 1'b0;
        encRqst = 1'b0;
        validIn = 1'b0;
        lastIn  = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i);
        rom[1] = 8'h12;
        rom[2] = 8'h05;
        repeat (3) @(negedge clk);
        #1 check_eq("reset", 32'(obs()), 32'd0);
        rst = 1'b1;

        set_pat(16'b00111, 16'b00100);
        run_txn(4, 0, 1'b0, -1);
        run_txn(0, 1, 1'b0, -1);
        set_pat(16'b11001, 16'b10000);
        run_txn(4, 0, 1'b0, -1);
        set_pat(16'h03FF, 16'h0000);
        run_txn(4, 2, 1'b0, -1);
        set_pat(16'b00111, 16'b00100);
        run_txn(4, 0, 1'b0, 6);
        run_txn(4, 0, 1'b0, -1);
        run_txn(4, 5, 1'b0, -1);
        run_txn(4, 0, 1'b0, -1);
        rand_pat();
        run_txn(255, 1, 1'b1, -1);
        for (int t = 0; t < 30; t++) begin
            rom[1] = 8'($urandom);
            rom[2] = 8'($urandom);
            rand_pat();
            run_txn($urandom_range(0, 10), $urandom_range(0, 3), 1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
